dmem_wait_responder: RTL
========================

// Module: dmem_wait_responder
// PURPOSE
//  Data-memory responder for the CPU's load/store port, with a req/ready/done handshake and a configurable
//  access latency. Used in place of the zero-wait data memory in multicycle/stall-capable cores.
//  Performs byte, half and word accesses with sign/zero extension, and reports out-of-range accesses.
// PARAMETERS
//  DEPTH_WORDS  1024  number of 32-bit words in the backing array (power of 2)
//  LATENCY      2     edges from request acceptance to done (legal range 1..15)
// PORTS
//  clk        in   1   single clock, all state updates on posedge
//  reset      in   1   synchronous, active-high
//  req        in   1   initiator requests an access; sampled only while ready=1
//  write      in   1   1=store, 0=load; sampled with req
//  address    in   32  byte address; sampled with req
//  writeData  in   32  store data, right-aligned; sampled with req
//  mode       in   3   000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned
//  ready      out  1   responder idle and able to accept a request
//  done       out  1   one-cycle pulse: access complete
//  readData   out  32  load result; valid while done=1 for loads, holds its value otherwise
//  err        out  1   valid while done=1: bad access (range or alignment); the access had no effect
// BEHAVIOUR
//  - Reset values: ready=1, done=0, readData=0, err=0, FSM=IDLE, counter=0.
//    Reset does not clear the memory array.
//  - FSM states:
//    - IDLE: ready=1. On an edge with req=1, latch write/address/writeData/mode, load the counter with LATENCY-1,
//      and go to BUSY.
//    - BUSY: ready=0. If the counter is nonzero, decrement it. If the counter is 0, perform the access,
//      register readData and err, and go to DONE.
//    - DONE: done=1, ready=0 for exactly one cycle, then go to IDLE.
//  - done rises on the LATENCY-th edge after the accepting edge. Back-to-back throughput is one access per
//    LATENCY+2 cycles.
//  - req while ready=0 is ignored; the initiator holds req until it sees ready.
//    Inputs changing during BUSY have no effect (latched copies are used).
//  - Word index = address[31:2]. Out of range (index >= DEPTH_WORDS): err=1, readData=0, store suppressed.
//  - Little-endian lanes:
//    - byte lane = address[1:0]; half lane = address[1].
//    - Stores: sb writes only the selected byte, sh only the selected half, sw all 4 bytes;
//      other bytes are unchanged.
//    - Loads: the selected byte or half is right-aligned; bits above it are sign-filled when mode[2]=0,
//      zero-filled when mode[2]=1.
//  - Modes 011, 110, 111 are illegal: err=1, no write, readData=0.
//  - A load and a store to the same word issued back to back: the load returns the post-store value,
//    because accesses are serialised.
//  - reset during BUSY: the pending access is aborted, no array write, no done pulse, FSM returns to IDLE.
// CONFIGURATION
//  DMEM_ALIGN_CHECK_EN
//    - Defined: half accesses with address[0]=1, and word accesses with address[1:0]!=0, give err=1;
//      the store is suppressed and readData=0.
//    - Undefined: misaligned low bits are forced to 0 (half: address[0] dropped; word: address[1:0] dropped),
//      the access proceeds, and err reflects only range and illegal-mode errors.
// TESTING
//  - Reset, then 5 idle cycles -> ready=1, done=0, err=0, readData=0 throughout.
//  - LATENCY=2: sw 0xDEADBEEF @0x10, then lw @0x10 -> each done exactly 2 edges after accept;
//    readData=0xDEADBEEF, err=0.
//  - Word 0x10 = 0x80FF7F01: lb @0x13 -> 0xFFFFFF80; lbu @0x13 -> 0x00000080; lh @0x12 -> 0xFFFF80FF;
//    lhu @0x10 -> 0x00007F01.
//  - sb 0xAA @0x11 over 0x11223344, then lw @0x10 -> 0x1122AA44; req held during BUSY is not double-accepted.
//  - sw @0x00001000 with DEPTH_WORDS=1024 -> err=1, the store is dropped, and a later lw @0x0 is unaffected.
//    sh @0x21: with DMEM_ALIGN_CHECK_EN, err=1 and memory unchanged; without it, the half is written at 0x20.
//  - reset asserted during BUSY of an sw -> no done pulse, ready=1 the next cycle, target word unchanged.

Source files
------------

// File: rtl/dmem_wait_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_wait_responder
// Description : Data-memory responder with req/ready/done handshake and a
//               fixed access latency. Byte/half/word loads and stores with
//               sign/zero extension and out-of-range reporting.
//               Optional macro DMEM_ALIGN_CHECK_EN flags misaligned accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_wait_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        write,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    input  logic [2:0]  mode,
    output logic        ready,
    output logic        done,
    output logic [31:0] readData,
    output logic        err
);
    localparam int         c_IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [3:0]          r_count;
    logic                r_write;
    logic [31:0]         r_address;
    logic [31:0]         r_wdata;
    logic [2:0]          r_mode;
    logic [31:0]         r_mem [DEPTH_WORDS];

    logic                w_accept;
    logic                w_fire;
    logic                w_is_half;
    logic                w_is_word;
    logic                w_illegal;
    logic                w_range_err;
    logic                w_misalign;
    logic                w_err;
    logic [1:0]          w_lane;
    logic [c_IDX_W-1:0]  w_index;
    logic [31:0]         w_word;
    logic [7:0]          w_byte;
    logic [15:0]         w_half;
    logic [31:0]         w_load;
    logic [31:0]         w_wlanes;
    logic [3:0]          w_be;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        ready        = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        case (r_state)
            S_IDLE: begin
                ready = 1'b1;
                if (req) begin
                    w_accept     = 1'b1;
                    w_next_state = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_count == 4'd0) begin
                    w_fire       = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                done         = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    assign w_is_half   = (r_mode[1:0] == 2'b01);
    assign w_is_word   = (r_mode[1:0] == 2'b10);
    assign w_illegal   = (r_mode[1:0] == 2'b11) || (r_mode == 3'b110);
    assign w_range_err = ({2'b00, r_address[31:2]} >= 32'(DEPTH_WORDS));

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misalign = (w_is_half && r_address[0]) || (w_is_word && (r_address[1:0] != 2'b00));
    assign w_lane     = r_address[1:0];
`else
    // Misaligned low address bits are dropped so the access proceeds naturally aligned.
    assign w_misalign = 1'b0;
    assign w_lane     = w_is_word ? 2'b00 : (w_is_half ? {r_address[1], 1'b0} : r_address[1:0]);
`endif

    assign w_err   = w_illegal || w_range_err || w_misalign;
    assign w_index = r_address[c_IDX_W+1:2];
    assign w_word  = r_mem[w_index];

    always_comb begin
        w_byte   = w_word[8*w_lane +: 8];
        w_half   = w_lane[1] ? w_word[31:16] : w_word[15:0];
        w_load   = w_word;
        w_be     = 4'b1111;
        w_wlanes = r_wdata;
        if (w_is_half) begin
            w_load   = {{16{w_half[15] & ~r_mode[2]}}, w_half};
            w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{r_wdata[15:0]}};
        end else if (!w_is_word) begin
            w_load   = {{24{w_byte[7] & ~r_mode[2]}}, w_byte};
            w_be     = 4'b0001 << w_lane;
            w_wlanes = {4{r_wdata[7:0]}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count   <= 4'd0;
            r_write   <= 1'b0;
            r_address <= 32'd0;
            r_wdata   <= 32'd0;
            r_mode    <= 3'd0;
            readData  <= 32'd0;
            err       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write   <= write;
                r_address <= address;
                r_wdata   <= writeData;
                r_mode    <= mode;
                r_count   <= c_CNT_INIT;
            end else if ((r_state == S_BUSY) && (r_count != 4'd0)) begin
                r_count <= r_count - 4'd1;
            end
            if (w_fire) begin
                err <= w_err;
                if (w_err)         readData <= 32'd0;
                else if (!r_write) readData <= w_load;
            end
        end
    end

    // The array is not reset; a reset coinciding with the access edge aborts the store.
    always_ff @(posedge clk) begin
        if (w_fire && !reset && r_write && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_index][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

endmodule
`default_nettype wire
